ram_bus_master_16x8: RTL and testbench

RAM_BUS_MASTER_16X8 -- requirements
Module: ram_bus_master_16x8

---
 rtl/ram_bus_pkg.sv | 22 ++
 rtl/ram_data_iobuf.sv | 21 ++
 rtl/single_port_ram_16x8.sv | 30 +++
 rtl/ram_bus_master_16x8.sv | 130 +++++++++++++
 tb/tb_ram_bus_master_16x8.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_bus_pkg.sv
// ---------------------------------------------------------------------------
// ram_bus_pkg
// Shared definitions for the 16x8 RAM bus master.
//   ADDR_W_DEF / DATA_W_DEF : default RAM geometry (16 locations x 8 bits)
//   LAT_CNT_W               : width of the read-latency down-counter (READ_LAT 1..4)
//   state_t                 : master FSM state encoding
// ---------------------------------------------------------------------------
package ram_bus_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int LAT_CNT_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_TURN = 3'd2,
    ST_RD   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

endpackage

// File: rtl/ram_data_iobuf.sv
// ---------------------------------------------------------------------------
// ram_data_iobuf
// Tri-state buffer for the shared RAM data bus.
//   oe   : drive enable (1 = pad driven with dout, 0 = pad released to Z)
//   dout : value driven onto the pad
//   din  : value currently seen on the pad
//   pad  : bidirectional bus
// ---------------------------------------------------------------------------
module ram_data_iobuf #(
  parameter int W = 8
) (
  input  logic         oe,
  input  logic [W-1:0] dout,
  output logic [W-1:0] din,
  inout  wire  [W-1:0] pad
);

  assign pad = oe ? dout : {W{1'bz}};
  assign din = pad;

endmodule

// File: rtl/single_port_ram_16x8.sv
// ---------------------------------------------------------------------------
// single_port_ram_16x8
// Simple single-port RAM with a shared bidirectional data bus.
//   clk      : clock, writes happen on the rising edge
//   write_en : store data into mem[addr] at the rising edge
//   read_en  : drive mem[addr] onto data while high (bus released otherwise)
//   addr     : location
//   data     : shared data bus
// ---------------------------------------------------------------------------
module single_port_ram_16x8 (
  input  logic       clk,
  input  logic       write_en,
  input  logic       read_en,
  input  logic [3:0] addr,
  inout  wire  [7:0] data
);

  logic [7:0] mem [16];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[addr] <= data;
    end
  end

  // The master holds addr stable for the whole read window, so the array
  // output can be presented directly on the bus while read_en is high.
  assign data = read_en ? mem[addr] : 8'bz;

endmodule

// File: rtl/ram_bus_master_16x8.sv
// ---------------------------------------------------------------------------
// ram_bus_master_16x8
// Converts a valid/ready request/response client interface into RAM strobes
// on a shared tri-state data bus.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_write/req_addr/req_wdata : request fields, captured at accept
//   rsp_valid/rsp_ready/rsp_rdata : read response handshake and data
//   write_en/read_en/addr      : registered RAM control
//   data                       : shared RAM data bus (driven only in WR)
//   busy                       : FSM not in IDLE
// Write: IDLE -> WR (1 cycle) -> TURN (1 cycle) -> IDLE.
// Read : IDLE -> RD (READ_LAT cycles) -> RESP (until rsp_ready) -> IDLE.
// ---------------------------------------------------------------------------
module ram_bus_master_16x8
  import ram_bus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              write_en,
  output logic              read_en,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  output logic              busy
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(READ_LAT - 1);

  state_t              state_reg, state_next;
  logic [LAT_CNT_W-1:0] lat_cnt_reg;
  logic                ready_en_reg;
  logic                write_en_reg, read_en_reg, data_oe_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rsp_rdata_reg;
  logic [DATA_W-1:0]   data_in;
  logic                accept;

  assign accept = req_valid && req_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = req_write ? ST_WR : ST_RD;
      ST_WR:   state_next = ST_TURN;
      ST_TURN: state_next = ST_IDLE;
      ST_RD:   if (lat_cnt_reg == '0) state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Client-side outputs decoded from the current state. ready_en_reg keeps
  // req_ready low during reset and releases it on the first edge after.
  always_comb begin
    req_ready = ready_en_reg && (state_reg == ST_IDLE);
    busy      = (state_reg != ST_IDLE);
    rsp_valid = (state_reg == ST_RESP);
  end

  // Datapath and registered RAM-side outputs. The strobes are loaded from
  // state_next so they line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_reg  <= 1'b0;
      lat_cnt_reg   <= '0;
      write_en_reg  <= 1'b0;
      read_en_reg   <= 1'b0;
      data_oe_reg   <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rsp_rdata_reg <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      write_en_reg <= (state_next == ST_WR);
      read_en_reg  <= (state_next == ST_RD);
      data_oe_reg  <= (state_next == ST_WR);

      if (accept) begin
        addr_reg    <= req_addr;
        wdata_reg   <= req_wdata;
        lat_cnt_reg <= LAT_LOAD;
      end else if (state_reg == ST_RD && lat_cnt_reg != '0) begin
        lat_cnt_reg <= lat_cnt_reg - 1'b1;
      end

      // Sample the bus on the edge that ends the last RD cycle.
      if (state_reg == ST_RD && lat_cnt_reg == '0) begin
        rsp_rdata_reg <= data_in;
      end
    end
  end

  assign write_en  = write_en_reg;
  assign read_en   = read_en_reg;
  assign addr      = addr_reg;
  assign rsp_rdata = rsp_rdata_reg;

  ram_data_iobuf #(
    .W (DATA_W)
  ) u_iobuf (
    .oe   (data_oe_reg),
    .dout (wdata_reg),
    .din  (data_in),
    .pad  (data)
  );

endmodule

// File: tb/tb_ram_bus_master_16x8.sv
// ---------------------------------------------------------------------------
// tb_ram_bus_master_16x8
// Directed bench: master (READ_LAT=1) and a second master (READ_LAT=3), each
// attached to its own single_port_ram_16x8.
// ---------------------------------------------------------------------------
module tb_ram_bus_master_16x8;

  logic       clk;
  logic       rst_n;

  // READ_LAT = 1 instance
  logic       req_valid, req_write, rsp_ready;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_ready, rsp_valid, write_en, read_en, busy;
  logic [3:0] addr;
  logic [7:0] rsp_rdata;
  wire  [7:0] data;

  // READ_LAT = 3 instance
  logic       req_valid3, req_write3, rsp_ready3;
  logic [3:0] req_addr3;
  logic [7:0] req_wdata3;
  logic       req_ready3, rsp_valid3, write_en3, read_en3, busy3;
  logic [3:0] addr3;
  logic [7:0] rsp_rdata3;
  wire  [7:0] data3;

  int n_cmp = 0;
  int n_err = 0;

  ram_bus_master_16x8 #(.ADDR_W(4), .DATA_W(8), .READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .write_en(write_en), .read_en(read_en), .addr(addr), .data(data),
    .busy(busy)
  );

  single_port_ram_16x8 u_ram (
    .clk(clk), .write_en(write_en), .read_en(read_en), .addr(addr), .data(data)
  );

  ram_bus_master_16x8 #(.ADDR_W(4), .DATA_W(8), .READ_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write3),
    .req_addr(req_addr3), .req_wdata(req_wdata3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3),
    .write_en(write_en3), .read_en(read_en3), .addr(addr3), .data(data3),
    .busy(busy3)
  );

  single_port_ram_16x8 u_ram3 (
    .clk(clk), .write_en(write_en3), .read_en(read_en3), .addr(addr3), .data(data3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge once req_ready is seen, return at the
  // negedge following the accepting edge.
  task automatic issue(input logic w, input logic [3:0] a, input logic [7:0] d);
    int n = 0;
    while (req_ready !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", req_ready, 1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    issue(1'b1, a, d);
    chk("wr_we",   write_en, 1);
    chk("wr_re",   read_en, 0);
    chk("wr_addr", addr, a);
    chk("wr_oe",   dut.data_oe_reg, 1);
    chk("wr_data", data, d);
    @(negedge clk);
    chk("turn_we",   write_en, 0);
    chk("turn_re",   read_en, 0);
    chk("turn_oe",   dut.data_oe_reg, 0);
    chk("turn_busy", busy, 1);
    @(negedge clk);
    chk("wr_idle_ready", req_ready, 1);
  endtask

  // Assumes rsp_ready=1.
  task automatic do_read(input logic [3:0] a, input logic [7:0] exp);
    issue(1'b0, a, 8'h00);
    chk("rd_re",   read_en, 1);
    chk("rd_we",   write_en, 0);
    chk("rd_addr", addr, a);
    chk("rd_oe",   dut.data_oe_reg, 0);
    @(negedge clk);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_rdata", rsp_rdata, exp);
    chk("resp_re",    read_en, 0);
    @(negedge clk);
    chk("post_valid", rsp_valid, 0);
    chk("post_ready", req_ready, 1);
  endtask

  // Bus protocol checks every cycle on both instances.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("proto_excl",  {31'd0, write_en && read_en}, 0);
      chk("proto_oe",    {31'd0, dut.data_oe_reg && !write_en}, 0);
      chk("proto_excl3", {31'd0, write_en3 && read_en3}, 0);
      chk("proto_oe3",   {31'd0, dut3.data_oe_reg && !write_en3}, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e;
    int re_cnt;
    int first_k;
    logic [7:0] rdata3_seen;

    rst_n = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    req_valid3 = 0; req_write3 = 0; req_addr3 = 0; req_wdata3 = 0; rsp_ready3 = 0;
    #2 rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_we",    write_en, 0);
    chk("rst_re",    read_en, 0);
    chk("rst_addr",  addr, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_oe",    dut.data_oe_reg, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", req_ready, 1);

    // Fill then read back a*17
    for (int a = 0; a < 16; a++) begin
      e = 8'(a * 17);
      do_write(4'(a), e);
    end
    rsp_ready = 1'b1;
    for (int a = 0; a < 16; a++) begin
      e = 8'(a * 17);
      do_read(4'(a), e);
    end

    // Back-pressure on addr 3, with req_valid pulses while busy
    do_write(4'd3, 8'hA5);
    rsp_ready = 1'b0;
    issue(1'b0, 4'd3, 8'h00);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 8'hA5);
      chk("bp_ready", req_ready, 0);
      chk("bp_we",    write_en, 0);
      chk("bp_re",    read_en, 0);
      req_valid = ~req_valid;
      req_write = 1'b1;
      req_addr  = 4'd3;
      req_wdata = 8'h00;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_busy",  busy, 0);
    chk("bp_rel_valid", rsp_valid, 0);
    chk("bp_rel_ready", req_ready, 1);
    do_read(4'd3, 8'hA5);

    // Write->read turnaround on addr 7
    do_write(4'd7, 8'h3C);
    do_read(4'd7, 8'h3C);
    do_read(4'd15, 8'hFF);
    do_read(4'd0, 8'h00);

    // Reset mid-RD at addr 5
    issue(1'b0, 4'd5, 8'h00);
    chk("mid_rd_re", read_en, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_we",    write_en, 0);
    chk("arst_re",    read_en, 0);
    chk("arst_oe",    dut.data_oe_reg, 0);
    chk("arst_valid", rsp_valid, 0);
    chk("arst_busy",  busy, 0);
    chk("arst_addr",  addr, 0);
    chk("arst_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_valid", rsp_valid, 0);
      chk("post_rst_re",    read_en, 0);
    end
    chk("post_rst_ready", req_ready, 1);

    // READ_LAT=3 instance: write 9=0x99, then read it back
    req_valid3 = 1'b1; req_write3 = 1'b1; req_addr3 = 4'd9; req_wdata3 = 8'h99;
    @(negedge clk);
    req_valid3 = 1'b0;
    chk("l3_wr_we", write_en3, 1);
    @(negedge clk);
    @(negedge clk);
    chk("l3_wr_ready", req_ready3, 1);
    rsp_ready3 = 1'b1;
    req_valid3 = 1'b1; req_write3 = 1'b0; req_addr3 = 4'd9;
    @(negedge clk);
    req_valid3 = 1'b0;
    re_cnt = 0;
    first_k = 0;
    rdata3_seen = 8'h00;
    for (int k = 1; k <= 6; k++) begin
      if (read_en3) re_cnt++;
      if (rsp_valid3 && first_k == 0) begin
        first_k = k;
        rdata3_seen = rsp_rdata3;
      end
      @(negedge clk);
    end
    chk("l3_re_cycles",   re_cnt, 3);
    chk("l3_first_valid", first_k, 4);
    chk("l3_rdata",       rdata3_seen, 8'h99);
    chk("l3_idle_ready",  req_ready3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
